// File: rtl/rv32_arb_pkg.sv
// Shared widths, FSM state type and latched bus-request record for the rv32 memory arbiter.
package rv32_arb_pkg;

  localparam int WORD_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_INSTR,
    ARB_GRANT_DATA
  } arb_state_t;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] write_value;
    logic [MASK_W-1:0] write_mask;
  } bus_req_t;

  // A fetch is always a plain read: no store data, no byte strobes.
  function automatic bus_req_t fetch_req(input logic [WORD_W-1:0] addr);
    bus_req_t r;
    r      = '0;
    r.addr = addr;
    return r;
  endfunction

endpackage

// File: rtl/rv32_mem_arbiter_if.sv
// Valid/ready memory request channel; the requester side is the master, the responder side the slave.
interface rv32_mem_arbiter_if;
  import rv32_arb_pkg::*;

  logic              valid;
  logic              write;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] write_value;
  logic [MASK_W-1:0] write_mask;
  logic              ready;
  logic [WORD_W-1:0] read_value;

  modport master (
    output valid, write, addr, write_value, write_mask,
    input  ready, read_value
  );

  modport slave (
    input  valid, write, addr, write_value, write_mask,
    output ready, read_value
  );

endinterface

// File: rtl/rv32_arb_pick.sv
// Combinational grant selection for the memory arbiter: data priority with a fetch starvation
// limit, or alternating round-robin when RV32_ARB_ROUND_ROBIN_EN is defined.
module rv32_arb_pick
  import rv32_arb_pkg::*;
#(
  parameter int CNT_W        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             instr_valid,
  input  logic             data_valid,
`ifdef RV32_ARB_ROUND_ROBIN_EN
  input  logic             last_grant,
`else
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  output logic             grant_instr,
  output logic             grant_data
);

`ifdef RV32_ARB_ROUND_ROBIN_EN
  // last_grant = 1 means data won last time, so a contested round goes to fetch.
  always_comb begin
    grant_data  = data_valid && (!instr_valid || !last_grant);
    grant_instr = instr_valid && !grant_data;
  end
`else
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic starved;

  always_comb begin
    starved     = instr_valid && (starve_cnt == LIMIT);
    grant_data  = data_valid && !starved;
    grant_instr = instr_valid && !grant_data;
  end
`endif

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Serialises fetch and data-port requests onto one single-port memory bus.
// Define RV32_ARB_ROUND_ROBIN_EN to replace data priority and the starvation counter with round-robin.
module rv32_mem_arbiter
  import rv32_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic               clk,
  input  logic               reset,
  rv32_mem_arbiter_if.slave  instr,
  rv32_mem_arbiter_if.slave  data,
  rv32_mem_arbiter_if.master bus
);

  arb_state_t state;
  arb_state_t state_next;
  bus_req_t   req_q;
  logic       grant_instr;
  logic       grant_data;
  logic       take_instr;
  logic       take_data;

`ifdef RV32_ARB_ROUND_ROBIN_EN
  logic last_grant;

  rv32_arb_pick #(
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .instr_valid (instr.valid),
    .data_valid  (data.valid),
    .last_grant  (last_grant),
    .grant_instr (grant_instr),
    .grant_data  (grant_data)
  );
`else
  logic [CNT_W-1:0] starve_cnt;

  rv32_arb_pick #(
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .instr_valid (instr.valid),
    .data_valid  (data.valid),
    .starve_cnt  (starve_cnt),
    .grant_instr (grant_instr),
    .grant_data  (grant_data)
  );
`endif

  // Grants only happen from IDLE, so a requester seen mid-transaction just waits.
  assign take_data  = (state == ARB_IDLE) && grant_data;
  assign take_instr = (state == ARB_IDLE) && grant_instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (take_data) begin
          state_next = ARB_GRANT_DATA;
        end else if (take_instr) begin
          state_next = ARB_GRANT_INSTR;
        end
      end
      ARB_GRANT_INSTR,
      ARB_GRANT_DATA: begin
        if (bus.ready) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Request fields are captured once at the grant and held until the bus finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
    end else if (take_data) begin
      req_q <= '{write:       data.write,
                 addr:        data.addr,
                 write_value: data.write_value,
                 write_mask:  data.write_mask};
    end else if (take_instr) begin
      req_q <= fetch_req(instr.addr);
    end
  end

`ifdef RV32_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (take_data) begin
      last_grant <= 1'b1;
    end else if (take_instr) begin
      last_grant <= 1'b0;
    end
  end
`else
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Counts data grants that overtook a waiting fetch; any other grant resets the streak.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (take_data && instr.valid) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else if (take_data || take_instr) begin
      starve_cnt <= '0;
    end
  end
`endif

  // A requester that dropped valid early gets no ready pulse; its response is discarded.
  always_comb begin
    bus.valid        = (state != ARB_IDLE);
    bus.write        = req_q.write;
    bus.addr         = req_q.addr;
    bus.write_value  = req_q.write_value;
    bus.write_mask   = req_q.write_mask;
    instr.ready      = 1'b0;
    instr.read_value = '0;
    data.ready       = 1'b0;
    data.read_value  = '0;
    if (!reset && bus.ready) begin
      if ((state == ARB_GRANT_INSTR) && instr.valid) begin
        instr.ready      = 1'b1;
        instr.read_value = bus.read_value;
      end
      if ((state == ARB_GRANT_DATA) && data.valid) begin
        data.ready      = 1'b1;
        data.read_value = bus.read_value;
      end
    end
  end

endmodule
